// File: rtl/sysbus_fabric.sv
// sysbus_fabric: single-master system bus decoder with per-region wait states.
// An 8-bit field of cpu_ab selects one of NSLV regions (lowest index wins).
// Waited regions hold cpu_ab stable while cpu_rdy is low. cpu_di is registered.
// Optional: define SYSBUS_BUSERR_EN to get the sticky bus_err flag and the
// first-fault address capture in err_addr. Without it, both outputs tie to 0.

// Per-region address comparator
module sysbus_slv_match #(
   parameter logic [7:0] MATCH = 8'h00,
   parameter logic [7:0] MASK  = 8'h00
)(
   input  logic [7:0] field,
   output logic       hit
);
   assign hit = ((field & MASK) == (MATCH & MASK));
endmodule

module sysbus_fabric #(
   parameter int                 DW           = 16,
   parameter int                 AW           = 32,
   parameter int                 NSLV         = 4,
   parameter int                 DEC_LO       = 16,
   parameter logic [NSLV*8-1:0]  SLV_MATCH    = 32'h00_FD_FE_FF,
   parameter logic [NSLV*8-1:0]  SLV_MASK     = 32'h80_FF_FF_FF,
   parameter logic [NSLV*8-1:0]  SLV_WAIT     = 32'h01_00_02_00,
   parameter logic [DW-1:0]      DEFAULT_DATA = '1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [AW-1:0]        cpu_ab,
   input  logic [DW-1:0]        cpu_do,
   input  logic                 cpu_we,
   output logic [DW-1:0]        cpu_di,
   output logic                 cpu_rdy,
   output logic [NSLV-1:0]      slv_sel,
   output logic                 slv_we,
   output logic [DW-1:0]        slv_wdata,
   input  logic [NSLV*DW-1:0]   slv_rdata,
   output logic                 bus_err,
   output logic [AW-1:0]        err_addr
);
   typedef enum logic [0:0] {IDLE, WAIT} state_t;

   // Access context frozen on entry to WAIT so that no re-decode happens mid-wait
   typedef struct packed {
      logic [NSLV-1:0] sel;
      logic [2:0]      idx;
   } acc_t;

   state_t          state;
   logic [3:0]      wcnt;
   acc_t            acc_q;

   logic [7:0]      field;
   logic [NSLV-1:0] hit;
   logic [NSLV-1:0] dec_sel;
   logic [2:0]      dec_idx;
   logic [7:0]      dec_wait;
   logic [NSLV-1:0] cur_sel;
   logic [2:0]      cur_idx;
   logic [DW-1:0]   rd_data;

   assign field = cpu_ab[DEC_LO+7:DEC_LO];

   for (genvar i = 0; i < NSLV; i++) begin : g_match
      sysbus_slv_match #(
         .MATCH (SLV_MATCH[i*8 +: 8]),
         .MASK  (SLV_MASK[i*8 +: 8])
      ) u_match (
         .field (field),
         .hit   (hit[i])
      );
   end

   // Priority pick: scan high to low so the lowest matching index is the survivor
   always_comb begin
      dec_sel  = '0;
      dec_idx  = '0;
      dec_wait = '0;
      for (int i = NSLV-1; i >= 0; i--) begin
         if (hit[i]) begin
            dec_sel    = '0;
            dec_sel[i] = 1'b1;
            dec_idx    = 3'(i);
            dec_wait   = SLV_WAIT[i*8 +: 8];
         end
      end
   end

   // Live decode in IDLE, frozen context while waiting
   always_comb begin
      cur_sel = dec_sel;
      cur_idx = dec_idx;
      cpu_rdy = (dec_wait == 8'd0);
      if (state == WAIT) begin
         cur_sel = acc_q.sel;
         cur_idx = acc_q.idx;
         cpu_rdy = (wcnt == 4'd0);
      end
   end

   assign rd_data   = (|cur_sel) ? slv_rdata[cur_idx*DW +: DW] : DEFAULT_DATA;
   assign slv_sel   = cur_sel;
   assign slv_we    = cpu_we & cpu_rdy & (|cur_sel);
   assign slv_wdata = cpu_do;

   // Wait-state FSM: the IDLE cycle counts as the first wait, so wcnt loads W-1.
   // Only the low 4 bits of a wait value are honoured.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wcnt  <= '0;
         acc_q <= '0;
      end else begin
         case (state)
            IDLE: if (dec_wait != 8'd0) begin
               state     <= WAIT;
               wcnt      <= 4'(dec_wait - 8'd1);
               acc_q.sel <= dec_sel;
               acc_q.idx <= dec_idx;
            end
            WAIT: if (wcnt == 4'd0) state <= IDLE;
                  else              wcnt  <= wcnt - 4'd1;
            default: state <= IDLE;
         endcase
      end
   end

   // Read data register: loads on a completing read, holds otherwise
   always_ff @(posedge clk) begin
      if (reset)                   cpu_di <= '0;
      else if (cpu_rdy && !cpu_we) cpu_di <= rd_data;
   end

`ifdef SYSBUS_BUSERR_EN
   // Sticky error flag. Only the first unmatched access records its address.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_err  <= 1'b0;
         err_addr <= '0;
      end else if (cpu_rdy && !(|cur_sel) && !bus_err) begin
         bus_err  <= 1'b1;
         err_addr <= cpu_ab;
      end
   end
`else
   assign bus_err  = 1'b0;
   assign err_addr = '0;
`endif

endmodule

// File: tb/tb_sysbus_fabric.sv
// Directed bench for sysbus_fabric with default parameters.
// Inputs change 1ns after posedge, and outputs are sampled 1ns later.
module tb_sysbus_fabric;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_ab;
   logic [15:0] cpu_do;
   logic        cpu_we;
   logic [15:0] cpu_di;
   logic        cpu_rdy;
   logic [3:0]  slv_sel;
   logic        slv_we;
   logic [15:0] slv_wdata;
   logic [63:0] slv_rdata;
   logic        bus_err;
   logic [31:0] err_addr;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef SYSBUS_BUSERR_EN
   localparam logic        EXP_ERR  = 1'b1;
   localparam logic [31:0] EXP_EADR = 32'h80C0_0000;
`else
   localparam logic        EXP_ERR  = 1'b0;
   localparam logic [31:0] EXP_EADR = 32'h0;
`endif

   always #5 clk = ~clk;

   sysbus_fabric u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_ab    (cpu_ab),
      .cpu_do    (cpu_do),
      .cpu_we    (cpu_we),
      .cpu_di    (cpu_di),
      .cpu_rdy   (cpu_rdy),
      .slv_sel   (slv_sel),
      .slv_we    (slv_we),
      .slv_wdata (slv_wdata),
      .slv_rdata (slv_rdata),
      .bus_err   (bus_err),
      .err_addr  (err_addr)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ab, input logic we, input logic [15:0] d);
      cpu_ab = ab;
      cpu_we = we;
      cpu_do = d;
      #1;
   endtask

   initial begin
      slv_rdata = {16'h7777, 16'h5555, 16'h1234, 16'hA55A};
      reset = 1'b1;
      drive(32'hFFFF_0000, 1'b0, 16'h0);
      tick();
      tick();
      chk("rst_di",   cpu_di,   16'h0);
      chk("rst_err",  bus_err,  1'b0);
      chk("rst_eadr", err_addr, 32'h0);
      reset = 1'b0;

      // zero-wait read, slave0
      drive(32'hFFFF_0010, 1'b0, 16'h0);
      chk("s0_rdy", cpu_rdy, 1'b1);
      chk("s0_sel", slv_sel, 4'b0001);
      tick();
      chk("s0_di",  cpu_di,  16'hA55A);
      chk("s0_rdy2", cpu_rdy, 1'b1);

      // two-wait read, slave1, then an immediate second access to the same slave
      drive(32'hFFFE_0000, 1'b0, 16'h0);
      chk("s1_rdy0", cpu_rdy, 1'b0);
      chk("s1_sel",  slv_sel, 4'b0010);
      tick();
      chk("s1_rdy1", cpu_rdy, 1'b0);
      chk("s1_sel1", slv_sel, 4'b0010);
      tick();
      chk("s1_rdy2", cpu_rdy, 1'b1);
      chk("s1_hold", cpu_di,  16'hA55A);
      tick();
      chk("s1_di",   cpu_di,  16'h1234);
      chk("b2b_rdy0", cpu_rdy, 1'b0);
      tick();
      chk("b2b_rdy1", cpu_rdy, 1'b0);
      tick();
      chk("b2b_rdy2", cpu_rdy, 1'b1);

      // zero-wait read, slave2
      tick();
      drive(32'hFFFD_0000, 1'b0, 16'h0);
      chk("s2_rdy", cpu_rdy, 1'b1);
      chk("s2_sel", slv_sel, 4'b0100);
      tick();
      chk("s2_di",  cpu_di,  16'h5555);

      // one-wait write, slave3
      drive(32'h0000_0123, 1'b1, 16'hBEEF);
      chk("w_rdy0", cpu_rdy,   1'b0);
      chk("w_we0",  slv_we,    1'b0);
      chk("w_sel0", slv_sel,   4'b1000);
      chk("w_dat",  slv_wdata, 16'hBEEF);
      tick();
      chk("w_rdy1", cpu_rdy,   1'b1);
      chk("w_we1",  slv_we,    1'b1);
      chk("w_sel1", slv_sel,   4'b1000);
      chk("w_di",   cpu_di,    16'h5555);
      tick();
      chk("w_we2",  slv_we,    1'b0);

      // unmatched reads: first fault is captured, second must not overwrite it
      drive(32'h80C0_0000, 1'b0, 16'h0);
      chk("um_rdy", cpu_rdy, 1'b1);
      chk("um_sel", slv_sel, 4'b0000);
      tick();
      chk("um_di",  cpu_di,  16'hFFFF);
      chk("um_err", bus_err, EXP_ERR);
      drive(32'h80C1_0000, 1'b1, 16'h4321);
      chk("um_we",  slv_we,  1'b0);
      drive(32'h80C1_0000, 1'b0, 16'h0);
      tick();
      chk("um2_di",   cpu_di,   16'hFFFF);
      chk("um2_err",  bus_err,  EXP_ERR);
      chk("um2_eadr", err_addr, EXP_EADR);

      // reset during the first wait cycle of a slave1 write
      drive(32'hFFFE_0000, 1'b1, 16'h1111);
      chk("rw_we0", slv_we, 1'b0);
      tick();
      reset = 1'b1;
      #1;
      chk("rw_we1",  slv_we,  1'b0);
      chk("rw_rdy1", cpu_rdy, 1'b0);
      tick();
      chk("rw_di",   cpu_di,   16'h0);
      chk("rw_err",  bus_err,  1'b0);
      chk("rw_eadr", err_addr, 32'h0);
      reset = 1'b0;
      drive(32'hFFFF_0010, 1'b0, 16'h0);
      chk("rw_idle", cpu_rdy, 1'b1);
      chk("rw_sel",  slv_sel, 4'b0001);
      tick();
      chk("rw_di2",  cpu_di,  16'hA55A);

      // fresh waited access after reset pays the full count
      drive(32'hFFFE_0000, 1'b0, 16'h0);
      chk("fr_rdy0", cpu_rdy, 1'b0);
      tick();
      chk("fr_rdy1", cpu_rdy, 1'b0);
      tick();
      chk("fr_rdy2", cpu_rdy, 1'b1);
      tick();
      chk("fr_di",   cpu_di,  16'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sysbus_fabric.md
SYSBUS_FABRIC -- requirements
Module: sysbus_fabric

Interface
REQ-001 SHALL have parameter DW, default 16: data width.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter NSLV, default 4: slave region count, range 1..8.
REQ-004 SHALL have parameter DEC_LO, default 16: LSB of the 8-bit decode field cpu_ab[DEC_LO+7:DEC_LO].
REQ-005 SHALL have parameters SLV_MATCH, SLV_MASK and SLV_WAIT, each flat NSLV*8 bits, slice i for slave i. Defaults:
- slave0: FF/FF/0
- slave1: FE/FF/2
- slave2: FD/FF/0
- slave3: 00/80/1
REQ-006 SHALL have parameter DEFAULT_DATA, default all-ones: read data returned for unmatched addresses.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all state on posedge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-009 SHALL have port cpu_ab, input, AW bits: CPU address.
REQ-010 SHALL have port cpu_do, input, DW bits: CPU write data.
REQ-011 SHALL have port cpu_we, input, 1 bit: CPU write enable.
REQ-012 SHALL have port cpu_di, output, DW bits: registered read data to the CPU.
REQ-013 SHALL have port cpu_rdy, output, 1 bit: CPU ready.
REQ-014 SHALL have port slv_sel, output, NSLV bits: one-hot region select.
REQ-015 SHALL have port slv_we, output, 1 bit: committed write strobe.
REQ-016 SHALL have port slv_wdata, output, DW bits: equals cpu_do.
REQ-017 SHALL have port slv_rdata, input, NSLV*DW bits: slave read data, slice i from slave i.
REQ-018 SHALL have port bus_err, output, 1 bit: sticky unmatched-access flag.
REQ-019 SHALL have port err_addr, output, AW bits: captured faulting address.

Function
REQ-020 SHALL match slave i when (field & MASK_i) == (MATCH_i & MASK_i); the lowest matching index wins, and slv_sel SHALL be one-hot or all-zero.
REQ-021 SHALL implement FSM states IDLE and WAIT, with a 4-bit counter wcnt.
REQ-022 In IDLE with matched slave i and SLV_WAIT_i = W:
- W = 0: cpu_rdy SHALL be 1 (zero-wait access).
- W > 0: cpu_rdy SHALL be 0, wcnt SHALL load W-1, and the FSM SHALL go to WAIT.
REQ-023 In WAIT, cpu_rdy SHALL be 0 while wcnt != 0 (wcnt decrements each cycle); when wcnt == 0, cpu_rdy SHALL be 1 and the FSM SHALL return to IDLE.
REQ-024 A W-wait access SHALL hold cpu_rdy low for exactly W cycles; cpu_rdy is a combinational function of state and decode.
REQ-025 On each posedge with cpu_rdy=1 and cpu_we=0, cpu_di SHALL load the selected slave slice (or DEFAULT_DATA if unmatched); otherwise cpu_di SHALL hold. Read latency is 1 cycle after the ready cycle.
REQ-026 slv_we SHALL equal cpu_we & cpu_rdy & |slv_sel, so each write commits in exactly one cycle regardless of wait states.
REQ-027 Unmatched accesses SHALL complete with zero wait, slv_sel=0, and no write strobe.
REQ-028 The CPU holds cpu_ab while cpu_rdy=0; address changes during WAIT are unsupported, and the FSM SHALL NOT re-decode until it is back in IDLE.
REQ-029 Back-to-back waited accesses SHALL each pay the full wait count, with no idle cycle inserted between them.

Reset
REQ-030 While reset=1 at a posedge:
- FSM SHALL go to IDLE, wcnt=0, cpu_di=0, bus_err=0, err_addr=0.
- Reset has priority over any in-progress wait, which is abandoned.
REQ-031 In the cycle after reset deassertion, the first access SHALL decode fresh from IDLE.

Configuration
REQ-032 With macro SYSBUS_BUSERR_EN defined:
- An unmatched access with cpu_rdy=1 while bus_err=0 SHALL set bus_err and capture cpu_ab into err_addr.
- Later faults SHALL NOT overwrite err_addr; only reset clears it.
REQ-033 With SYSBUS_BUSERR_EN undefined, bus_err and err_addr SHALL be constant 0 and no error logic SHALL be synthesised.

Verification
REQ-034 Read 0xFFFF0010, slave0 rdata=0xA55A -> cpu_rdy stays 1; cpu_di=0xA55A one cycle later.
REQ-035 Read 0xFFFE0000 (wait 2), slave1 rdata=0x1234 -> cpu_rdy low 2 cycles, high on the 3rd; cpu_di=0x1234 on the 4th.
REQ-036 Write 0x00000123 data 0xBEEF (slave3, wait 1) -> slv_we high exactly one cycle, coincident with cpu_rdy=1; slv_sel=4'b1000.
REQ-037 Reset asserted in the 1st wait cycle of a slave1 access -> next cycle IDLE, cpu_di=0, and no slv_we pulse.
REQ-038 With SYSBUS_BUSERR_EN, read 0x80C00000 (unmatched) then 0x80C10000 -> cpu_di=0xFFFF, bus_err=1, err_addr=0x80C00000; without the macro, bus_err stays 0.
